// File: rtl/wb_trace_recorder_pkg.sv
// Trace entry layout and event kind codes shared by the recorder and its FIFO.
package trace_pkg;

  localparam logic KIND_GRF      = 1'b0;
  localparam logic KIND_DM       = 1'b1;
  localparam int   TRACE_ENTRY_W = 97;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_recorder_fifo.sv
// Two-write/one-read circular buffer with occupancy count; writes land next cycle.
// Caller must never assert push1_vld without push0_vld or exceed free space.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = TRACE_ENTRY_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0_vld,
  input  logic [W-1:0]               push0_dat,
  input  logic                       push1_vld,
  input  logic [W-1:0]               push1_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // Pointers are power-of-two wide, so wrap is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push0_vld) mem[wptr] <= push0_dat;
      if (push1_vld) mem[wptr + PW'(1)] <= push1_dat;
      wptr  <= wptr + PW'(push0_vld) + PW'(push1_vld);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(push0_vld) + CW'(push1_vld) - CW'(pop);
    end
  end

  assign head_dat = mem[rptr];

endmodule

// File: rtl/wb_trace_recorder.sv
// Orders GRF/DM write events (GRF first) into a show-ahead FIFO; 1-cycle latency, valid/ready pop.
// Events that do not fit are dropped and latch trace_overflow; TRACE_FILTER_ZERO_EN drops $0 writes.
module wb_trace_recorder
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       grf_we,
  input  logic [31:0]                grf_pc,
  input  logic [4:0]                 grf_addr,
  input  logic [31:0]                grf_data,
  input  logic                       dm_we,
  input  logic [31:0]                dm_pc,
  input  logic [31:0]                dm_addr,
  input  logic [31:0]                dm_data,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic                       trace_kind,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_addr,
  output logic [31:0]                trace_data,
  output logic                       trace_overflow,
  output logic [$clog2(DEPTH+1)-1:0] trace_count
);

  localparam int CW = $clog2(DEPTH+1);

  trace_entry_t grf_e, dm_e, push0_dat, head;
  logic         grf_evt, dm_evt, pop, push0_vld, push1_vld, drop;
  logic         has1, has2;
  logic [CW:0]  free;

`ifdef TRACE_FILTER_ZERO_EN
  assign grf_evt = grf_we && (grf_addr != 5'd0);
`else
  assign grf_evt = grf_we;
`endif
  assign dm_evt = dm_we;

  assign grf_e = '{kind: KIND_GRF, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_data};
  assign dm_e  = '{kind: KIND_DM,  pc: dm_pc,  addr: dm_addr,           data: dm_data};

  assign pop  = trace_valid && trace_ready;
  // A pop this cycle frees its slot for a push at the same edge.
  assign free = (CW+1)'(DEPTH) - {1'b0, trace_count} + (CW+1)'(pop);
  assign has1 = free >= (CW+1)'(1);
  assign has2 = free >= (CW+1)'(2);

  always_comb begin
    push0_vld = 1'b0;
    push1_vld = 1'b0;
    push0_dat = grf_e;
    drop      = 1'b0;
    if (!reset) begin
      if (grf_evt) begin
        push0_vld = has1;
        push1_vld = dm_evt && has2;
        drop      = !has1 || (dm_evt && !has2);
      end else if (dm_evt) begin
        push0_vld = has1;
        push0_dat = dm_e;
        drop      = !has1;
      end
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .W(TRACE_ENTRY_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push0_vld (push0_vld),
    .push0_dat (push0_dat),
    .push1_vld (push1_vld),
    .push1_dat (dm_e),
    .pop       (pop),
    .head_dat  (head),
    .count     (trace_count)
  );

  always_ff @(posedge clk) begin
    if (reset)     trace_overflow <= 1'b0;
    else if (drop) trace_overflow <= 1'b1;
  end

  assign trace_valid = trace_count != '0;
  assign trace_kind  = trace_valid ? head.kind : 1'b0;
  assign trace_pc    = trace_valid ? head.pc   : 32'd0;
  assign trace_addr  = trace_valid ? head.addr : 32'd0;
  assign trace_data  = trace_valid ? head.data : 32'd0;

endmodule

// File: doc/wb_trace_recorder.md
# wb_trace_recorder

Captures architectural write events from the pipelined CPU (GRF write-back in W, data-memory store in M) and queues them in program order for a downstream consumer (bench monitor, UART dumper, or on-chip trace buffer) over a valid/ready port. It sits beside `mips`, tapping its W- and M-stage write strobes, and is the reading end of the write stream the CPU produces. It converts up to two events per cycle into one ordered event per accepted handshake.

## Interface

- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `grf_we`  in  1  W-stage GRF write strobe.
- `grf_pc`  in  32  PC of the writing instruction.
- `grf_addr`  in  5  destination register.
- `grf_data`  in  32  value written.
- `dm_we`  in  1  M-stage store strobe.
- `dm_pc`  in  32  PC of the store.
- `dm_addr`  in  32  byte address, word-aligned.
- `dm_data`  in  32  stored word.
- `trace_valid`  out  1  head entry available.
- `trace_ready`  in  1  consumer accepts head this cycle.
- `trace_kind`  out  1  0 = GRF, 1 = DM.
- `trace_pc`  out  32  event PC.
- `trace_addr`  out  32  DM address, or GRF index zero-extended.
- `trace_data`  out  32  event data.
- `trace_overflow`  out  1  sticky: an event was dropped.
- `trace_count`  out  $clog2(DEPTH+1)  occupied entries.

## Operation

- Pop when `trace_valid && trace_ready`; head advances at the clock edge.
- Push per cycle: up to two entries. When both strobes are high, GRF event is enqueued first (older instruction), DM event second.
- Free slots this cycle = `DEPTH - trace_count + pop`; a same-cycle pop makes room for a push.
- Insufficient room: with one free slot and two events, GRF event enqueued, DM event dropped; with zero free slots, both dropped. Any drop sets `trace_overflow`; only `reset` clears it.
- Pointers wrap modulo DEPTH; `trace_count` never exceeds DEPTH.
- Outputs are show-ahead: `trace_*` fields reflect the head entry whenever `trace_valid` is 1; undefined-but-stable contents irrelevant when `trace_valid` is 0 (drive zero).
- Reset values: `trace_valid`=0, `trace_kind`/`trace_pc`/`trace_addr`/`trace_data`=0, `trace_overflow`=0, `trace_count`=0. Reset mid-stream discards all queued entries and ignores strobes in that cycle.

## Timing

- Event at edge N (strobe sampled high) visible on `trace_*` after edge N, i.e. cycle N+1 when the FIFO was empty; one-cycle latency, no combinational path from strobes to outputs.
- Two simultaneous events into empty FIFO: GRF at N+1, DM at the cycle after GRF is popped.
- `trace_ready` held high: sustained throughput one event per cycle; `trace_count` changes by push−pop each edge (range −1..+2).
- `trace_ready` may toggle freely; `trace_valid` never drops without a pop or reset.

## Configuration

- `TRACE_FILTER_ZERO_EN` defined: GRF events with `grf_addr == 0` are discarded before enqueue (never consume space, never set overflow). Undefined: `$0` writes are recorded like any other.

## Structure

- Package `trace_pkg`: `KIND_GRF`=1'b0, `KIND_DM`=1'b1, `TRACE_ENTRY_W`=97, packed entry typedef {kind, pc, addr, data}.
- Sub-module `trace_fifo`: two-write/one-read circular buffer with count; `wb_trace_recorder` does event ordering, filtering, drop/overflow logic.

## Test plan

- Single GRF write ($8 ← 0x1234, pc 0x3000), ready=1 -> one cycle later kind=0, addr=8, data=0x1234, pc=0x3000; then valid=0.
- Same-cycle GRF (pc 0x3004) and DM (pc 0x3008, addr 0x10, data 0xFF) -> GRF pops first, DM next cycle; count 2→1→0.
- ready=0, 17 single events with DEPTH=16 -> count=16, overflow=1, first 16 events drained intact in order.
- count=15, both strobes, ready=0 -> GRF enqueued, DM dropped, overflow=1; repeat with ready=1 and valid head -> both accepted, count=16, overflow stays as before.
- `$0` write: with `TRACE_FILTER_ZERO_EN` -> count unchanged; without -> entry addr=0 emitted.
- Reset asserted with 5 entries queued -> next cycle valid=0, count=0, overflow=0; strobes in reset cycle not captured.
